// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: double-buffered digit/dot data,
// optional hex glyphs, leading-zero blanking and PWM brightness on the anodes.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int HEX_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  lzb,
  input  logic                  blank,
  input  logic [3:0]            bright,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [3:0]          pwm;
  logic [4*DIGITS-1:0] shadow_digits, act_digits;
  logic [DIGITS-1:0]   shadow_dots, act_dots;
  logic                slot_end, frame_end;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                zero_run;
  logic [DIGITS-1:0]   sel;

  assign slot_end  = (presc == LAST_PRE);
  assign frame_end = slot_end && (idx == LAST_IDX);

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      4'd10:   glyph = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000001;
      4'd11:   glyph = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000001;
      4'd12:   glyph = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000001;
      4'd13:   glyph = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000001;
      4'd14:   glyph = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000001;
      default: glyph = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000001;
    endcase
  endfunction

  // Walk from the most significant digit down so zero_run says whether this
  // digit and everything above it is zero.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    cur_nib  = 4'd0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    sel      = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_digits[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        cur_nib = act_digits[4*i +: 4];
        cur_dp  = act_dots[i];
        cur_lz  = zero_run && (i != 0);
        sel[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      pwm        <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      pwm        <= pwm + 4'd1;
      frame_done <= frame_end;
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the display buffers are reset so a freshly reset board shows zeros, not garbage.
      shadow_digits <= '0;
      shadow_dots   <= '0;
      act_digits    <= '0;
      act_dots      <= '0;
      pending       <= 1'b0;
    end else begin
      if (load) begin
        shadow_digits <= digits;
        shadow_dots   <= dots;
      end
      if (frame_end && load) begin
        act_digits <= digits;
        act_dots   <= dots;
        pending    <= 1'b0;
      end else if (frame_end && pending) begin
        act_digits <= shadow_digits;
        act_dots   <= shadow_dots;
        pending    <= 1'b0;
      end else if (load) begin
        pending    <= 1'b1;
      end
    end
  end

  // seg and an are registered together so the anode never leads its pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'd0;
      an  <= '0;
    end else begin
      seg <= {(lzb && cur_lz) ? 7'd0 : glyph(cur_nib), cur_dp};
      an  <= (!blank && (pwm <= bright)) ? sel : '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a hex and a dash instance share stimulus,
// expected per-cycle frames are queued at load time and drained as the DUT scans.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic        lzb;
  logic        blank;
  logic [3:0]  bright;

  logic [7:0]  seg_h, seg_d;
  logic [3:0]  an_h, an_d;
  logic        fd_h, fd_d;
  logic        pend_h, pend_d;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] seg_h;
    logic [7:0] seg_d;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dots(dots),
    .lzb(lzb), .blank(blank), .bright(bright),
    .seg(seg_h), .an(an_h), .frame_done(fd_h), .pending(pend_h)
  );

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0)) dut_dash (
    .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dots(dots),
    .lzb(lzb), .blank(blank), .bright(bright),
    .seg(seg_d), .an(an_d), .frame_done(fd_d), .pending(pend_d)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] v, input bit hex);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return hex ? 7'b1110111 : 7'b0000001;
      4'hB: return hex ? 7'b0011111 : 7'b0000001;
      4'hC: return hex ? 7'b1001110 : 7'b0000001;
      4'hD: return hex ? 7'b0111101 : 7'b0000001;
      4'hE: return hex ? 7'b1001111 : 7'b0000001;
      default: return hex ? 7'b1000111 : 7'b0000001;
    endcase
  endfunction

  // Push the 16 cycles of one frame: 4 cycles per digit, frame_done on the last.
  task automatic expect_frame(input logic [15:0] d, input logic [3:0] dt, input bit lz);
    exp_t e;
    logic [3:0]  nib;
    logic [15:0] upper;
    bit          blanked;
    for (int s = 0; s < 4; s++) begin
      nib     = d[4*s +: 4];
      upper   = d >> (4 * s);
      blanked = lz && (s > 0) && (upper == 16'd0);
      e.seg_h = {blanked ? 7'd0 : ref_glyph(nib, 1'b1), dt[s]};
      e.seg_d = {blanked ? 7'd0 : ref_glyph(nib, 1'b0), dt[s]};
      e.an    = 4'b0001 << s;
      for (int r = 0; r < 4; r++) begin
        e.fd = (s == 3) && (r == 3);
        sb.push_back(e);
      end
    end
  endtask

  // Start at the negedge showing frame_done; drain 16 scoreboard entries.
  task automatic check_frame(input string name);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s cyc%0d scoreboard empty", name, i);
      end else begin
        e = sb.pop_front();
        if ({seg_h, seg_d, an_h, an_d, fd_h, fd_d} !== {e.seg_h, e.seg_d, e.an, e.an, e.fd, e.fd}) begin
          failures++;
          $display("FAIL %s cyc%0d seg_h=%b seg_d=%b an=%b/%b fd=%b/%b expected seg_h=%b seg_d=%b an=%b fd=%b",
                   name, i, seg_h, seg_d, an_h, an_d, fd_h, fd_d, e.seg_h, e.seg_d, e.an, e.fd);
        end
      end
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (fd_h === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s frame_done timeout got=0 expected=1", name);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dt);
    digits = d;
    dots   = dt;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({seg_h, an_h, fd_h, pend_h, seg_d, an_d} !== 22'd0) begin
      failures++;
      $display("FAIL reset seg=%b an=%b fd=%b pend=%b expected all 0", seg_h, an_h, fd_h, pend_h);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    do_load(16'h1234, 4'b0100);
    checks++;
    if (pend_h !== 1'b1) begin
      failures++;
      $display("FAIL basic_pending_set got=%b expected=1", pend_h);
    end
    wait_frame("basic_sync");
    checks++;
    if (pend_h !== 1'b0) begin
      failures++;
      $display("FAIL basic_pending_clear got=%b expected=0", pend_h);
    end
    expect_frame(16'h1234, 4'b0100, 1'b0);
    check_frame("basic_f1");
    expect_frame(16'h1234, 4'b0100, 1'b0);
    check_frame("basic_f2");
  endtask

  task automatic test_atomic();
    expect_frame(16'h1234, 4'b0100, 1'b0);
    fork
      check_frame("atomic_old");
      begin
        repeat (5) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        checks++;
        if (pend_h !== 1'b1) begin
          failures++;
          $display("FAIL atomic_pend1 got=%b expected=1", pend_h);
        end
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        repeat (3) @(negedge clk);
        checks++;
        if (pend_h !== 1'b1) begin
          failures++;
          $display("FAIL atomic_pend2 got=%b expected=1", pend_h);
        end
      end
    join
    checks++;
    if (pend_h !== 1'b0) begin
      failures++;
      $display("FAIL atomic_pend_clear got=%b expected=0", pend_h);
    end
    expect_frame(16'h2222, 4'b0000, 1'b0);
    check_frame("atomic_new");
  endtask

  task automatic test_simultaneous();
    expect_frame(16'h2222, 4'b0000, 1'b0);
    fork
      check_frame("simul_old");
      begin
        repeat (15) @(negedge clk);
        digits = 16'h5555;
        dots   = 4'b0000;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        checks++;
        if (pend_h !== 1'b0) begin
          failures++;
          $display("FAIL simul_pending got=%b expected=0", pend_h);
        end
      end
    join
    expect_frame(16'h5555, 4'b0000, 1'b0);
    check_frame("simul_new");
    checks++;
    if (pend_h !== 1'b0) begin
      failures++;
      $display("FAIL simul_pending_after got=%b expected=0", pend_h);
    end
  endtask

  task automatic test_hex();
    do_load(16'hABCF, 4'b0000);
    wait_frame("hex_sync");
    expect_frame(16'hABCF, 4'b0000, 1'b0);
    check_frame("hex_dash");
  endtask

  task automatic test_lzb();
    lzb = 1'b1;
    do_load(16'h0007, 4'b0000);
    wait_frame("lzb7_sync");
    expect_frame(16'h0007, 4'b0000, 1'b1);
    check_frame("lzb_0007");
    do_load(16'h0000, 4'b0010);
    wait_frame("lzb0_sync");
    expect_frame(16'h0000, 4'b0010, 1'b1);
    check_frame("lzb_0000");
    lzb = 1'b0;
  endtask

  task automatic test_bright_blank();
    int on_cnt;
    bright = 4'd3;
    @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an_h !== 4'd0) on_cnt++;
    end
    checks++;
    if (on_cnt != 4) begin
      failures++;
      $display("FAIL bright3 on_cycles=%0d expected=4", on_cnt);
    end
    bright = 4'd15;
    blank  = 1'b1;
    @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an_h !== 4'd0 || an_d !== 4'd0) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin
      failures++;
      $display("FAIL blank on_cycles=%0d expected=0", on_cnt);
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (6) @(negedge clk);
    checks++;
    if (an_h === 4'd0) begin
      failures++;
      $display("FAIL pre_reset_an got=%b expected nonzero", an_h);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg_h, an_h, fd_h, pend_h} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset seg=%b an=%b fd=%b pend=%b expected all 0", seg_h, an_h, fd_h, pend_h);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame("post_reset_sync");
    expect_frame(16'h0000, 4'b0000, 1'b0);
    check_frame("post_reset_clear");
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    digits = 16'h0000;
    dots   = 4'b0000;
    lzb    = 1'b0;
    blank  = 1'b0;
    bright = 4'd15;
    test_reset();
    test_basic();
    test_atomic();
    test_simultaneous();
    test_hex();
    test_lzb();
    test_bright_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
